// File: rtl/pagetable_sram_if.sv
`default_nettype none
// ============================================================================
// pagetable_sram_if : request/response bundle for the page-table SRAM
// Rev 1.0
// ============================================================================
interface pagetable_sram_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              clear_start;
  logic              init_busy;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, clear_start,
    input  req_ready, init_busy, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, clear_start,
    output req_ready, init_busy, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pagetable_sram.sv
`default_nettype none
// ============================================================================
// pagetable_sram : single-port table SRAM with zero-fill and pipelined reads
// Rev 1.0
// ============================================================================
module pagetable_sram #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int READ_LAT   = 1,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  pagetable_sram_if.slave bus
);
  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_END = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_ready;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]   dat_q [READ_LAT];
  logic [DATA_W-1:0]   dat_d [READ_LAT];

  assign req_ready = (state_q == RUN) && !rst;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.req_addr;
    mem_wdata = bus.req_wdata;
    unique case (state_q)
      CLEAR: begin
        mem_we    = !rst;
        mem_waddr = cnt_q[ADDR_W-1:0];
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        // Leave once the last address has been written; the extra counter bit
        // lets the terminal count be seen without wrapping.
        if (cnt_d == CNT_END) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d  = '0;
        mem_we = accept && bus.req_we;
        if (INIT_CLEAR && bus.clear_start) begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Read pipeline: data captured at acceptance; each stage holds when idle so
  // the output keeps its last value between responses.
  always_comb begin
    vld_d[0] = accept && !bus.req_we;
    dat_d[0] = vld_d[0] ? mem[bus.req_addr] : dat_q[0];
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_CLEAR ? CLEAR : RUN;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.init_busy = rst ? INIT_CLEAR : (state_q == CLEAR);
  assign bus.rsp_valid = vld_q[READ_LAT-1] && !rst;
  assign bus.rsp_rdata = rst ? '0 : dat_q[READ_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_pagetable_sram.sv
`default_nettype none
// ============================================================================
// tb_pagetable_sram : randomized + directed bench against a table-level model
// Rev 1.0
// ============================================================================
module tb_pagetable_sram;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;
  localparam int READ_LAT   = 2;
  localparam bit INIT_CLEAR = 1'b1;
  localparam int DEPTH      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pagetable_sram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pagetable_sram #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .READ_LAT  (READ_LAT),
    .INIT_CLEAR(INIT_CLEAR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [DATA_W-1:0] m_mem [DEPTH];
  rsp_t              m_q [$];
  int                m_busy;
  int                cyc;
  logic              exp_valid;
  logic [DATA_W-1:0] exp_rdata;
  int                checks;
  int                errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic step(input int v, input int we, input int a, input int d,
                      input int clr, input int r);
    logic [ADDR_W-1:0] ai;
    rsp_t              e;
    ai              = ADDR_W'(a);
    bus.req_valid   = (v != 0);
    bus.req_we      = (we != 0);
    bus.req_addr    = ai;
    bus.req_wdata   = DATA_W'(d);
    bus.clear_start = (clr != 0);
    rst             = (r != 0);
    @(posedge clk);
    cyc++;
    exp_valid = 1'b0;
    if (r != 0) begin
      m_q.delete();
      m_busy    = DEPTH;
      exp_rdata = '0;
    end else begin
      if (m_busy > 0) begin
        m_mem[DEPTH - m_busy] = '0;
        m_busy--;
      end else begin
        if (v != 0 && we != 0) begin
          m_mem[ai] = DATA_W'(d);
        end else if (v != 0) begin
          e.due  = cyc + READ_LAT - 1;
          e.data = m_mem[ai];
          m_q.push_back(e);
        end
        if (clr != 0) m_busy = DEPTH;
      end
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        e         = m_q.pop_front();
        exp_valid = 1'b1;
        exp_rdata = e.data;
      end
    end
    #1;
    check("req_ready", 32'(bus.req_ready), 32'((r == 0) && (m_busy == 0)));
    check("init_busy", 32'(bus.init_busy), 32'((r != 0) ? INIT_CLEAR : (m_busy > 0)));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_busy(input int n);
    for (int k = 0; k < n; k++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 255), $urandom_range(0, 1), 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    m_busy    = DEPTH;
    exp_valid = 1'b0;
    exp_rdata = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset with junk on the request inputs, then the full zero-fill.
    for (int k = 0; k < 3; k++) step(1, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), 8'h5A, 1, 1);
    rnd_busy(DEPTH);
    for (int i = 0; i < 16; i++) step(1, 0, i, 0, 0, 0);
    step(1, 0, DEPTH - 1, 0, 0, 0);
    idle(READ_LAT + 1);

    // Write then read-after-write next cycle.
    step(1, 1, 'h1F3, 'hA5, 0, 0);
    step(1, 0, 'h1F3, 0, 0, 0);
    idle(READ_LAT + 1);

    // Random traffic concentrated on a few addresses.
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 255), 0, 0);
    idle(READ_LAT + 1);

    // Back-to-back reads of a preloaded block.
    for (int i = 0; i < 8; i++) step(1, 1, i, 'h10 + i, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, i, 0, 0, 0);
    idle(READ_LAT + 1);

    // Read accepted on the same edge as clear_start, then clear runs.
    step(1, 1, 5, 'h3C, 0, 0);
    step(1, 0, 5, 0, 1, 0);
    rnd_busy(DEPTH);
    step(1, 0, 5, 0, 0, 0);
    idle(READ_LAT + 1);

    // Reset one cycle after a read is accepted.
    step(1, 1, 3, 'h77, 0, 0);
    step(1, 0, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    rnd_busy(DEPTH / 2);

    // Reset mid-clear restarts the fill from address 0.
    step(0, 0, 0, 0, 0, 1);
    rnd_busy(DEPTH);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 3, 0, 0, 0);
    step(1, 0, DEPTH - 1, 0, 0, 0);
    idle(READ_LAT + 1);

    // Top and bottom address independence.
    step(1, 1, DEPTH - 1, 'hEF, 0, 0);
    step(1, 0, DEPTH - 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(READ_LAT + 1);

    // Mixed random traffic with occasional clears.
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
           ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 255), $urandom_range(0, 255) == 0, 0);
    idle(READ_LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pagetable_sram.md
PAGETABLE_SRAM -- requirements
Module: pagetable_sram

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes SHALL occur on the rising edge of clk.
REQ-002 Parameter ADDR_W SHALL default to 13 and set the address width; depth is 2**ADDR_W entries.
REQ-003 Parameter DATA_W SHALL default to 8 and set the entry width.
REQ-004 Parameter READ_LAT SHALL default to 1; the legal range is 1..3 and sets the read latency in cycles.
REQ-005 Parameter INIT_CLEAR SHALL default to 1; when 1, the block zero-fills the array after reset.
REQ-006 Port list (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: request can be accepted.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: entry index.
- req_wdata, in, DATA_W: write data.
- clear_start, in, 1: pulse to re-run the zero-fill.
- init_busy, out, 1: zero-fill in progress.
- rsp_valid, out, 1: read data valid, single-cycle pulse.
- rsp_rdata, out, DATA_W: read data.

Function
REQ-007 The FSM SHALL have exactly two states, CLEAR and RUN.
REQ-008 In CLEAR, a counter SHALL write 0 to addresses 0, 1, ..., 2**ADDR_W-1, one per cycle, then go to RUN on the cycle after the last address is written.
REQ-009 In CLEAR, init_busy=1 and req_ready=0.
REQ-010 In RUN, init_busy=0 and req_ready=1, so one request can be accepted every cycle.
REQ-011 A request SHALL be accepted on an edge where req_valid && req_ready; request inputs are ignored on all other edges.
REQ-012 An accepted write SHALL update mem[req_addr] at the accepting edge and SHALL produce no response.
REQ-013 An accepted read SHALL assert rsp_valid for exactly one cycle, READ_LAT cycles after the accepting edge, with rsp_rdata = mem[addr] as sampled at the accepting edge.
REQ-014 Reads SHALL be fully pipelined, with responses returned in acceptance order and no response backpressure.
REQ-015 Read-after-write: a read of address A accepted on the cycle after a write to A SHALL return the new data.
REQ-016 A read and a write to the same address cannot be accepted on the same edge (single port).
REQ-017 A clear_start pulse in RUN SHALL enter CLEAR on the next edge with the counter at 0.
- If a request is accepted on the same edge, that request SHALL complete normally; clear_start takes effect afterwards.
REQ-018 clear_start SHALL be ignored while in CLEAR.
REQ-019 Reads already in flight when CLEAR is entered SHALL still deliver their response at the scheduled cycle, using data sampled at their acceptance.
REQ-020 When rsp_valid=0, rsp_rdata SHALL hold its last value.
REQ-021 The counter SHALL be ADDR_W+1 bits wide so that the terminal count 2**ADDR_W is detected without wrapping to 0.
REQ-022 When INIT_CLEAR=0, reset SHALL go directly to RUN, clear_start SHALL be ignored, and memory contents are undefined until written.

Reset
REQ-023 While rst=1, the block SHALL hold rsp_valid=0, rsp_rdata=0, req_ready=0, and init_busy=INIT_CLEAR.
REQ-024 On the first edge with rst=0, the FSM SHALL be in CLEAR (INIT_CLEAR=1) or RUN (INIT_CLEAR=0), with the counter at 0.
REQ-025 Reset asserted mid-operation SHALL flush the read pipeline: no rsp_valid pulse on any cycle after the reset edge.
REQ-026 Reset asserted mid-clear SHALL restart the zero-fill from address 0 after release.
REQ-027 Reset SHALL NOT otherwise alter memory contents.

Verification
REQ-028 Zero-fill after reset, ADDR_W=4: release rst -> init_busy=1 for exactly 16 cycles, then req_ready=1; reads of addresses 0..15 all return 0x00.
REQ-029 Write/read latency, READ_LAT=2: write 0xA5 to 0x1F3 in cycle N, read 0x1F3 in cycle N+1 -> rsp_valid=1 in cycle N+3 only, with rsp_rdata=0xA5.
REQ-030 Back-to-back pipeline, READ_LAT=3: 8 consecutive reads of addresses 0..7 preloaded with 0x10..0x17 -> 8 consecutive rsp_valid pulses returning 0x10..0x17 in order.
REQ-031 Clear mid-traffic, READ_LAT=2: read of 0x005 (holding 0x3C) accepted on the same edge as clear_start -> rsp_rdata=0x3C delivered at its scheduled cycle; req_ready stays 0 for 2**ADDR_W cycles; a later read of 0x005 returns 0x00.
REQ-032 Reset mid-pipeline, READ_LAT=3: rst asserted 1 cycle after a read is accepted -> rsp_valid stays 0 on every following cycle; zero-fill restarts at address 0.
REQ-033 Width sweep, DATA_W=16, ADDR_W=13: write 0xBEEF to 0x1FFF (top address), read it back -> 0xBEEF; address 0x0000 is unaffected.
